// File: rtl/instr_encoder_writer.sv
// Encodes MIPS instruction commands into 32-bit words and streams them into instruction memory.
// One-cycle command-to-write latency through a small FIFO; cmd_ready_o depends only on FIFO occupancy.

// Synchronous FIFO with an extra wrap bit on each pointer to tell full from empty.
module iew_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] head_dat_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_push, do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_dat_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset: entries are only visible once pushed.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end
endmodule

module instr_encoder_writer #(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [2:0]        cmd_kind_i,
  input  logic [4:0]        cmd_rs_i,
  input  logic [4:0]        cmd_rt_i,
  input  logic [4:0]        cmd_rd_i,
  input  logic [5:0]        cmd_funct_i,
  input  logic [15:0]       cmd_imm_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_data_o,
  input  logic              mem_ready_i,
  output logic [ADDR_W:0]   wr_count_o,
  output logic              err_o
);
  localparam logic [2:0] KIND_R    = 3'd0;
  localparam logic [2:0] KIND_BEQ  = 3'd1;
  localparam logic [2:0] KIND_ADDI = 3'd2;
  localparam logic [2:0] KIND_SLTI = 3'd3;

  logic [31:0]       enc_dat;
  logic              enc_legal;
  logic              cmd_acc;
  logic              push;
  logic              wr_done;
  logic              fifo_full, fifo_empty;
  logic [31:0]       head_dat;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   wr_count_q, wr_count_d;
  logic              err_q, err_d;

  always_comb begin
    enc_dat   = 32'h0;
    enc_legal = 1'b1;
    case (cmd_kind_i)
      KIND_R:    enc_dat = {6'b000000, cmd_rs_i, cmd_rt_i, cmd_rd_i, 5'b00000, cmd_funct_i};
      KIND_BEQ:  enc_dat = {6'b000100, cmd_rs_i, cmd_rt_i, cmd_imm_i};
      KIND_ADDI: enc_dat = {6'b001000, cmd_rs_i, cmd_rt_i, cmd_imm_i};
      KIND_SLTI: enc_dat = {6'b001010, cmd_rs_i, cmd_rt_i, cmd_imm_i};
      default:   enc_legal = 1'b0;
    endcase
  end

  // Illegal kinds are consumed so the sender never stalls on them.
  assign cmd_ready_o = !fifo_full;
  assign cmd_acc     = cmd_valid_i && cmd_ready_o;
  assign push        = cmd_acc && enc_legal;

  iew_fifo #(.W(32), .DEPTH(DEPTH)) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (push),
    .push_dat_i (enc_dat),
    .pop_i      (wr_done),
    .head_dat_o (head_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign mem_we_o   = !fifo_empty;
  assign mem_data_o = fifo_empty ? 32'h0 : head_dat;
  assign mem_addr_o = addr_q;
  assign wr_count_o = wr_count_q;
  assign err_o      = err_q;
  assign wr_done    = mem_we_o && mem_ready_i;

  // Address wraps to zero naturally, not back to BASE_ADDR.
  always_comb begin
    addr_d     = addr_q;
    wr_count_d = wr_count_q;
    err_d      = err_q || (cmd_acc && !enc_legal);
    if (wr_done) begin
      addr_d = addr_q + 1'b1;
      if (wr_count_q != {(ADDR_W+1){1'b1}}) wr_count_d = wr_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q     <= ADDR_W'(BASE_ADDR);
      wr_count_q <= '0;
      err_q      <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      wr_count_q <= wr_count_d;
      err_q      <= err_d;
    end
  end
endmodule

// File: tb/tb_instr_encoder_writer.sv
// Scoreboard bench: stimulus queues expected {addr,data} writes, monitors pop on each completed write.
`timescale 1ns/1ps
module tb_instr_encoder_writer;
  logic        clk = 0;
  logic        rst = 1;
  logic        cmd_valid = 0, cmd_valid2 = 0;
  logic [2:0]  cmd_kind = 0;
  logic [4:0]  cmd_rs = 0, cmd_rt = 0, cmd_rd = 0;
  logic [5:0]  cmd_funct = 0;
  logic [15:0] cmd_imm = 0;
  logic        mem_ready = 0, mem_ready2 = 1;

  logic        cmd_ready, mem_we, err;
  logic [7:0]  mem_addr;
  logic [31:0] mem_data;
  logic [8:0]  wr_count;

  logic        cmd_ready2, mem_we2, err2;
  logic [1:0]  mem_addr2;
  logic [31:0] mem_data2;
  logic [2:0]  wr_count2;

  int n_cmp = 0, n_bad = 0;
  logic [39:0] q1[$], q2[$];
  logic [7:0]  exp_addr1 = 0, exp_addr2 = 0;

  always #5 clk = ~clk;

  instr_encoder_writer #(.DEPTH(4), .ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_kind_i(cmd_kind), .cmd_rs_i(cmd_rs), .cmd_rt_i(cmd_rt), .cmd_rd_i(cmd_rd),
    .cmd_funct_i(cmd_funct), .cmd_imm_i(cmd_imm), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_data_o(mem_data), .mem_ready_i(mem_ready), .wr_count_o(wr_count), .err_o(err));

  instr_encoder_writer #(.DEPTH(4), .ADDR_W(2), .BASE_ADDR(0)) dut2 (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid2), .cmd_ready_o(cmd_ready2),
    .cmd_kind_i(cmd_kind), .cmd_rs_i(cmd_rs), .cmd_rt_i(cmd_rt), .cmd_rd_i(cmd_rd),
    .cmd_funct_i(cmd_funct), .cmd_imm_i(cmd_imm), .mem_we_o(mem_we2), .mem_addr_o(mem_addr2),
    .mem_data_o(mem_data2), .mem_ready_i(mem_ready2), .wr_count_o(wr_count2), .err_o(err2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && mem_we && mem_ready) begin
      if (q1.size() == 0) check("dut_unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
      else begin
        logic [39:0] e;
        e = q1.pop_front();
        check("dut_wr_addr", 32'(mem_addr), 32'(e[39:32]));
        check("dut_wr_data", mem_data, e[31:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && mem_we2 && mem_ready2) begin
      if (q2.size() == 0) check("dut2_unexpected_write", 32'(mem_addr2), 32'hFFFF_FFFF);
      else begin
        logic [39:0] e;
        e = q2.pop_front();
        check("dut2_wr_addr", 32'(mem_addr2), 32'(e[39:32]));
        check("dut2_wr_data", mem_data2, e[31:0]);
      end
    end
  end

  task automatic drive_cmd(input bit sel, input logic [2:0] kind, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] funct,
                           input logic [15:0] imm, input logic [31:0] expw);
    cmd_kind = kind; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd; cmd_funct = funct; cmd_imm = imm;
    if (sel) cmd_valid2 = 1; else cmd_valid = 1;
    if (kind < 3'd4) begin
      if (sel) begin q2.push_back({exp_addr2, expw}); exp_addr2 = (exp_addr2 + 1) & 8'h03; end
      else     begin q1.push_back({exp_addr1, expw}); exp_addr1 = exp_addr1 + 1; end
    end
  endtask

  task automatic wait_accept(input bit sel);
    logic rdy;
    bit   done = 0;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      rdy = sel ? cmd_ready2 : cmd_ready;
      @(posedge clk); #1;
      if (rdy) done = 1;
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
    cmd_valid = 0; cmd_valid2 = 0;
  endtask

  task automatic send(input bit sel, input logic [2:0] kind, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] funct,
                      input logic [15:0] imm, input logic [31:0] expw);
    drive_cmd(sel, kind, rs, rt, rd, funct, imm, expw);
    wait_accept(sel);
  endtask

  task automatic wait_count(input int target);
    bit done = 0;
    for (int t = 0; t < 100 && !done; t++) begin
      @(posedge clk); #1;
      if (int'(wr_count) == target) done = 1;
    end
    check("drain_wr_count", 32'(wr_count), 32'(target));
  endtask

  task automatic do_reset();
    rst = 1; cmd_valid = 0; cmd_valid2 = 0;
    @(posedge clk); #1;
    rst = 0;
    q1.delete(); q2.delete();
    exp_addr1 = 0; exp_addr2 = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_data", mem_data, 32'd0);
    check("rst_count", 32'(wr_count), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);

    // Single ADDI: one-cycle latency
    mem_ready = 1;
    send(0, 3'd2, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0005, 32'h2022_0005);
    check("lat_we", 32'(mem_we), 32'd1);
    check("lat_data", mem_data, 32'h2022_0005);
    @(posedge clk); #1;
    check("t1_count", 32'(wr_count), 32'd1);

    // Back-to-back stream at full throughput
    do_reset();
    send(0, 3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0000, 32'h0022_1820);
    send(0, 3'd1, 5'd4, 5'd5, 5'd0, 6'd0, 16'hFFFE, 32'h1085_FFFE);
    send(0, 3'd3, 5'd3, 5'd6, 5'd0, 6'd0, 16'h000A, 32'h2866_000A);
    @(posedge clk); #1;
    check("t2_count_consec", 32'(wr_count), 32'd3);

    // Backpressure: fill, verify stall stability, then drain
    do_reset();
    mem_ready = 0;
    for (int i = 0; i < 4; i++)
      send(0, 3'd2, 5'd0, 5'd0, 5'd0, 6'd0, 16'(16'h10 + i), 32'h2000_0010 + 32'(i));
    check("t3_full_ready", 32'(cmd_ready), 32'd0);
    drive_cmd(0, 3'd2, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0014, 32'h2000_0014);
    repeat (3) @(posedge clk);
    #1;
    check("t3_stall_data", mem_data, 32'h2000_0010);
    check("t3_stall_addr", 32'(mem_addr), 32'd0);
    check("t3_stall_ready", 32'(cmd_ready), 32'd0);
    mem_ready = 1;
    wait_accept(0);
    wait_count(5);

    // Illegal kind between two ADDIs
    do_reset();
    send(0, 3'd2, 5'd1, 5'd1, 5'd0, 6'd0, 16'h0001, 32'h2021_0001);
    check("t4_err_before", 32'(err), 32'd0);
    send(0, 3'd5, 5'd7, 5'd7, 5'd7, 6'h3F, 16'hFFFF, 32'h0);
    check("t4_err_set", 32'(err), 32'd1);
    send(0, 3'd2, 5'd2, 5'd2, 5'd0, 6'd0, 16'h0002, 32'h2042_0002);
    wait_count(2);
    repeat (2) @(posedge clk);
    #1;
    check("t4_err_sticky", 32'(err), 32'd1);
    check("t4_count", 32'(wr_count), 32'd2);

    // Reset with words buffered and memory stalled
    mem_ready = 0;
    for (int i = 0; i < 3; i++)
      send(0, 3'd2, 5'd0, 5'd0, 5'd0, 6'd0, 16'(i), 32'h2000_0000 + 32'(i));
    check("t6_buffered_we", 32'(mem_we), 32'd1);
    do_reset();
    check("t6_we", 32'(mem_we), 32'd0);
    check("t6_addr", 32'(mem_addr), 32'd0);
    check("t6_count", 32'(wr_count), 32'd0);
    check("t6_err", 32'(err), 32'd0);
    check("t6_ready", 32'(cmd_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("t6_still_idle", 32'(mem_we), 32'd0);

    // Address wrap on the 2-bit instance
    for (int i = 0; i < 5; i++)
      send(1, 3'd3, 5'd1, 5'd2, 5'd0, 6'd0, 16'(i), 32'h2822_0000 + 32'(i));
    repeat (3) @(posedge clk);
    #1;
    check("t5_count", 32'(wr_count2), 32'd5);
    check("t5_addr_after", 32'(mem_addr2), 32'd1);

    check("q1_drained", 32'(q1.size()), 32'd0);
    check("q2_drained", 32'(q2.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
